// File: rtl/gc_unit.sv
// rtl/gc_unit.sv - shared global counter with round-robin per-core grant and host reload
module gc_unit #(
    parameter int N_CORE   = 4,
    parameter int GC_WIDTH = 16,
    parameter int PW       = (N_CORE > 1) ? $clog2(N_CORE) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CORE-1:0]   req_valid,
    output logic [N_CORE-1:0]   req_ready,
    output logic [GC_WIDTH-1:0] gc,
    input  logic                set_valid,
    input  logic [GC_WIDTH-1:0] set_value,
    output logic [PW-1:0]       grant_id,
    output logic                grant,
    output logic                wrapped
);

    logic [GC_WIDTH-1:0] r_cnt;
    logic [PW-1:0]       r_ptr;
    logic                r_wrapped;

    logic [N_CORE-1:0]   w_req_ready;
    logic [PW-1:0]       w_grant_id;
    logic                w_grant;
    logic [PW-1:0]       w_ptr_next;

    // Round-robin scan starting at the pointer; a reload or reset blocks every grant.
    always_comb begin
        int idx;
        w_req_ready = '0;
        w_grant_id  = '0;
        w_grant     = 1'b0;
        idx         = 0;
        if (rst_n && !set_valid) begin
            for (int k = 0; k < N_CORE; k++) begin
                idx = (int'(r_ptr) + k) % N_CORE;
                if (!w_grant && req_valid[idx]) begin
                    w_grant          = 1'b1;
                    w_req_ready[idx] = 1'b1;
                    w_grant_id       = PW'(idx);
                end
            end
        end
    end

    // Pointer moves to the core just after the one granted.
    always_comb begin
        w_ptr_next = PW'((int'(w_grant_id) + 1) % N_CORE);
    end

    // Counter, pointer and wrap flag; reload has priority over grants.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_wrapped <= 1'b0;
        end else if (set_valid) begin
            r_cnt     <= set_value;
            r_wrapped <= 1'b0;
        end else if (w_grant) begin
            r_cnt <= r_cnt + 1'b1;
            r_ptr <= w_ptr_next;
            if (&r_cnt) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign grant_id  = w_grant_id;
    assign grant     = w_grant;
    assign gc        = r_cnt;
    assign wrapped   = r_wrapped;

endmodule

// File: tb/tb_gc_unit.sv
// tb/tb_gc_unit.sv - randomized and directed self-checking bench for gc_unit
module tb_gc_unit;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [W-1:0]  gc;
    logic          set_valid;
    logic [W-1:0]  set_value;
    logic [PW-1:0] grant_id;
    logic          grant;
    logic          wrapped;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    int m_cnt;
    int m_ptr;
    int m_wrapped;

    // what the last step observed
    int last_gc;
    int last_gid;
    int last_ready;
    int last_grant;
    int last_wrapped;

    gc_unit #(.N_CORE(N), .GC_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .gc        (gc),
        .set_valid (set_valid),
        .set_value (set_value),
        .grant_id  (grant_id),
        .grant     (grant),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic [N-1:0] v, input logic sv, input logic [W-1:0] sval, input logic rn);
        int exp_ready;
        int exp_gid;
        int got_g;
        int idx;
        @(negedge clk);
        req_valid = v;
        set_valid = sv;
        set_value = sval;
        rst_n     = rn;
        #1;
        exp_ready = 0;
        exp_gid   = 0;
        got_g     = 0;
        if (rn && !sv) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (got_g == 0 && v[idx]) begin
                    got_g     = 1;
                    exp_gid   = idx;
                    exp_ready = 1 << idx;
                end
            end
        end
        last_gc      = int'(gc);
        last_gid     = int'(grant_id);
        last_ready   = int'(req_ready);
        last_grant   = int'(grant);
        last_wrapped = int'(wrapped);
        check("gc", 32'(gc), 32'(m_cnt));
        check("wrapped", 32'(wrapped), 32'(m_wrapped));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("grant", 32'(grant), 32'(got_g));
        check("grant_id", 32'(grant_id), 32'(exp_gid));
        if (!rn) begin
            m_cnt = 0; m_ptr = 0; m_wrapped = 0;
        end else if (sv) begin
            m_cnt = int'(sval); m_wrapped = 0;
        end else if (got_g != 0) begin
            if (m_cnt == 65535) m_wrapped = 1;
            m_cnt = (m_cnt + 1) % 65536;
            m_ptr = (exp_gid + 1) % N;
        end
    endtask

    initial begin
        logic [N-1:0] rv;
        logic         rs;
        logic [W-1:0] rval;
        logic         rr;

        rst_n = 1'b0; req_valid = '0; set_valid = 1'b0; set_value = '0;
        repeat (2) @(posedge clk);
        m_cnt = 0; m_ptr = 0; m_wrapped = 0;
        step(4'b1111, 1'b0, 16'h0, 1'b0);
        check("rst_ready", 32'(last_ready), 32'd0);

        // single core 2 request
        step(4'b0100, 1'b0, 16'h0, 1'b1);
        check("t1_ready", 32'(last_ready), 32'b0100);
        check("t1_gid", 32'(last_gid), 32'd2);
        check("t1_gc", 32'(last_gc), 32'd0);
        step(4'b0000, 1'b0, 16'h0, 1'b1);
        check("t1_gc_next", 32'(last_gc), 32'd1);
        step(4'b1111, 1'b0, 16'h0, 1'b1);
        check("t1_ptr3", 32'(last_gid), 32'd3);

        // all cores, 8 cycles from reset
        step(4'b0000, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b0, 16'h0, 1'b1);
            check("t2_gid", 32'(last_gid), 32'(i % 4));
            check("t2_gc", 32'(last_gc), 32'(i));
        end
        step(4'b0000, 1'b0, 16'h0, 1'b1);
        check("t2_gc_after", 32'(last_gc), 32'd8);

        // set collides with requests from cores 1 and 3
        step(4'b1010, 1'b1, 16'h0100, 1'b1);
        check("t3_ready", 32'(last_ready), 32'd0);
        step(4'b1010, 1'b0, 16'h0, 1'b1);
        check("t3_gid1", 32'(last_gid), 32'd1);
        check("t3_gc1", 32'(last_gc), 32'h0100);
        step(4'b1000, 1'b0, 16'h0, 1'b1);
        check("t3_gid3", 32'(last_gid), 32'd3);
        check("t3_gc3", 32'(last_gc), 32'h0101);

        // wrap
        step(4'b0000, 1'b1, 16'hFFFE, 1'b1);
        step(4'b0001, 1'b0, 16'h0, 1'b1);
        check("t4_r0", 32'(last_gc), 32'hFFFE);
        step(4'b0001, 1'b0, 16'h0, 1'b1);
        check("t4_r1", 32'(last_gc), 32'hFFFF);
        check("t4_wr_lo", 32'(last_wrapped), 32'd0);
        step(4'b0001, 1'b0, 16'h0, 1'b1);
        check("t4_r2", 32'(last_gc), 32'h0000);
        check("t4_wr_hi", 32'(last_wrapped), 32'd1);
        step(4'b0000, 1'b1, 16'h0005, 1'b1);
        step(4'b0000, 1'b0, 16'h0, 1'b1);
        check("t4_wr_clr", 32'(last_wrapped), 32'd0);

        // core 0 loses to core 3 then withdraws
        step(4'b0000, 1'b0, 16'h0, 1'b0);
        step(4'b0100, 1'b0, 16'h0, 1'b1);
        step(4'b1001, 1'b0, 16'h0, 1'b1);
        check("t5_gid", 32'(last_gid), 32'd3);
        step(4'b0000, 1'b0, 16'h0, 1'b1);
        check("t5_gc", 32'(last_gc), 32'd2);
        check("t5_ready", 32'(last_ready), 32'd0);

        // reset mid-burst
        for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, 16'h0, 1'b1);
        step(4'b1111, 1'b0, 16'h0, 1'b0);
        check("t6_ready", 32'(last_ready), 32'd0);
        step(4'b1111, 1'b0, 16'h0, 1'b1);
        check("t6_gc", 32'(last_gc), 32'd0);
        check("t6_gid", 32'(last_gid), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rv   = N'($urandom_range(0, 15));
            rs   = ($urandom_range(0, 15) == 0);
            rval = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'(16'hFFF0 + $urandom_range(0, 15));
            rr   = ($urandom_range(0, 63) != 0);
            step(rv, rs, rval, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
